match_controller: RTL and testbench

//  Parametrised best-of-N match sequencer for the two-player fighter; successor to the fixed single-round game flow.

---
 rtl/match_controller.sv | 193 +++++++++++++++++++
 tb/tb_match_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Best-of-N match sequencer: countdown, fight timer, KO/timeout judging, win tallies
// and the per-round player reset pulse, all on the per-frame game clock.
module match_controller #(
    parameter int FRAME_HZ      = 60,
    parameter int COUNTDOWN_S   = 3,
    parameter int ROUND_TIME_S  = 99,
    parameter int RESULT_HOLD_S = 2,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int HEALTH_W      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [HEALTH_W-1:0] p1_health,
    input  logic [HEALTH_W-1:0] p2_health,
    output logic [2:0]          game_state,
    output logic [6:0]          secs_left,
    output logic [3:0]          round_num,
    output logic [2:0]          p1_wins,
    output logic [2:0]          p2_wins,
    output logic [1:0]          round_winner,
    output logic [1:0]          match_winner,
    output logic                round_reset
);

    localparam int FW = (FRAME_HZ > 1) ? $clog2(FRAME_HZ) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_HZ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4
    } state_t;

    state_t          state_q;
    logic [FW-1:0]   frame_q;
    logic [6:0]      secs_q;
    logic [3:0]      round_q;
    logic [2:0]      p1_wins_q;
    logic [2:0]      p2_wins_q;
    logic [1:0]      round_winner_q;
    logic [1:0]      match_winner_q;
    logic            round_reset_q;
    logic            start_q;

    logic            start_rise_d;
    logic            phase_done_d;
    logic [1:0]      round_result_d;

    assign start_rise_d = start & ~start_q;
    // Last frame of the final second of the current timed phase.
    assign phase_done_d = (frame_q == FRAME_LAST) && (secs_q == 7'd1);

    // Judge the fight this frame: KO has priority over timer expiry.
    always_comb begin
        round_result_d = 2'd0;
        if ((p1_health == '0) && (p2_health == '0)) begin
            round_result_d = 2'd3;
        end else if (p2_health == '0) begin
            round_result_d = 2'd1;
        end else if (p1_health == '0) begin
            round_result_d = 2'd2;
        end else if (phase_done_d) begin
            if (p1_health > p2_health) begin
                round_result_d = 2'd1;
            end else if (p2_health > p1_health) begin
                round_result_d = 2'd2;
            end else begin
                round_result_d = 2'd3;
            end
        end else begin
            round_result_d = 2'd0;
        end
    end

    // Match sequencer state, timers, tallies and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            frame_q        <= '0;
            secs_q         <= 7'd0;
            round_q        <= 4'd0;
            p1_wins_q      <= 3'd0;
            p2_wins_q      <= 3'd0;
            round_winner_q <= 2'd0;
            match_winner_q <= 2'd0;
            round_reset_q  <= 1'b0;
            start_q        <= 1'b1;
        end else begin
            start_q       <= start;
            round_reset_q <= 1'b0;
            case (state_q)
                S_IDLE, S_MATCH_END: begin
                    if (start_rise_d) begin
                        state_q        <= S_COUNTDOWN;
                        frame_q        <= '0;
                        secs_q         <= 7'(COUNTDOWN_S);
                        round_q        <= 4'd1;
                        p1_wins_q      <= 3'd0;
                        p2_wins_q      <= 3'd0;
                        round_winner_q <= 2'd0;
                        match_winner_q <= 2'd0;
                        round_reset_q  <= 1'b1;
                    end
                end
                S_COUNTDOWN: begin
                    if (phase_done_d) begin
                        state_q <= S_FIGHT;
                        frame_q <= '0;
                        secs_q  <= 7'(ROUND_TIME_S);
                    end else if (frame_q == FRAME_LAST) begin
                        frame_q <= '0;
                        secs_q  <= secs_q - 7'd1;
                    end else begin
                        frame_q <= frame_q + FW'(1);
                    end
                end
                S_FIGHT: begin
                    if (round_result_d != 2'd0) begin
                        state_q        <= S_ROUND_END;
                        frame_q        <= '0;
                        secs_q         <= 7'(RESULT_HOLD_S);
                        round_winner_q <= round_result_d;
                        if (round_result_d == 2'd1) begin
                            p1_wins_q <= p1_wins_q + 3'd1;
                        end
                        if (round_result_d == 2'd2) begin
                            p2_wins_q <= p2_wins_q + 3'd1;
                        end
                    end else if (frame_q == FRAME_LAST) begin
                        frame_q <= '0;
                        secs_q  <= secs_q - 7'd1;
                    end else begin
                        frame_q <= frame_q + FW'(1);
                    end
                end
                S_ROUND_END: begin
                    if (phase_done_d) begin
                        frame_q <= '0;
                        if (p1_wins_q == 3'(ROUNDS_TO_WIN)) begin
                            state_q        <= S_MATCH_END;
                            secs_q         <= 7'd0;
                            match_winner_q <= 2'd1;
                        end else if (p2_wins_q == 3'(ROUNDS_TO_WIN)) begin
                            state_q        <= S_MATCH_END;
                            secs_q         <= 7'd0;
                            match_winner_q <= 2'd2;
                        end else if (round_q == 4'(MAX_ROUNDS)) begin
                            state_q <= S_MATCH_END;
                            secs_q  <= 7'd0;
                            if (p1_wins_q > p2_wins_q) begin
                                match_winner_q <= 2'd1;
                            end else if (p2_wins_q > p1_wins_q) begin
                                match_winner_q <= 2'd2;
                            end else begin
                                match_winner_q <= 2'd3;
                            end
                        end else begin
                            state_q        <= S_COUNTDOWN;
                            secs_q         <= 7'(COUNTDOWN_S);
                            round_q        <= round_q + 4'd1;
                            round_winner_q <= 2'd0;
                            round_reset_q  <= 1'b1;
                        end
                    end else if (frame_q == FRAME_LAST) begin
                        frame_q <= '0;
                        secs_q  <= secs_q - 7'd1;
                    end else begin
                        frame_q <= frame_q + FW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    frame_q <= '0;
                    secs_q  <= 7'd0;
                end
            endcase
        end
    end

    assign game_state   = state_q;
    assign secs_left    = secs_q;
    assign round_num    = round_q;
    assign p1_wins      = p1_wins_q;
    assign p2_wins      = p2_wins_q;
    assign round_winner = round_winner_q;
    assign match_winner = match_winner_q;
    assign round_reset  = round_reset_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a small frame rate so whole matches run quickly.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] p1_health;
    logic [2:0] p2_health;
    logic [2:0] game_state;
    logic [6:0] secs_left;
    logic [3:0] round_num;
    logic [2:0] p1_wins;
    logic [2:0] p2_wins;
    logic [1:0] round_winner;
    logic [1:0] match_winner;
    logic       round_reset;

    int n_cmp = 0;
    int n_err = 0;

    match_controller #(
        .FRAME_HZ(4), .COUNTDOWN_S(2), .ROUND_TIME_S(3), .RESULT_HOLD_S(1),
        .ROUNDS_TO_WIN(2), .MAX_ROUNDS(3), .HEALTH_W(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_health(p1_health), .p2_health(p2_health),
        .game_state(game_state), .secs_left(secs_left), .round_num(round_num),
        .p1_wins(p1_wins), .p2_wins(p2_wins),
        .round_winner(round_winner), .match_winner(match_winner),
        .round_reset(round_reset)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic restart();
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; p1_health = 3'd5; p2_health = 3'd5;
        step(2);
        chk("rst_state", game_state, 0);
        chk("rst_pulse", round_reset, 0);
        rst = 1'b0;
        step(3);
        chk("held_start_idle", game_state, 0);
        chk("idle_secs", secs_left, 0);
        chk("idle_round", round_num, 0);
        chk("idle_wins", {p1_wins, p2_wins}, 0);

        // match 1: P1 wins by two KOs
        restart();
        chk("m1_cd_state", game_state, 1);
        chk("m1_cd_pulse", round_reset, 1);
        chk("m1_cd_secs", secs_left, 2);
        chk("m1_cd_round", round_num, 1);
        step(1);
        chk("m1_pulse_drop", round_reset, 0);
        step(6);
        chk("m1_cd_last", game_state, 1);
        chk("m1_cd_last_secs", secs_left, 1);
        step(1);
        chk("m1_fight", game_state, 2);
        chk("m1_fight_secs", secs_left, 3);
        step(4);
        chk("m1_fight_c5", game_state, 2);
        p2_health = 3'd0;
        step(1);
        chk("m1_r1_end", game_state, 3);
        chk("m1_r1_winner", round_winner, 1);
        chk("m1_r1_p1wins", p1_wins, 1);
        chk("m1_r1_hold_secs", secs_left, 1);
        p2_health = 3'd5;
        step(3);
        chk("m1_r1_hold", game_state, 3);
        step(1);
        chk("m1_r2_cd", game_state, 1);
        chk("m1_r2_round", round_num, 2);
        chk("m1_r2_pulse", round_reset, 1);
        step(8);
        chk("m1_r2_fight", game_state, 2);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        chk("start_ignored_fight", game_state, 2);
        p2_health = 3'd0;
        step(1);
        chk("m1_r2_p1wins", p1_wins, 2);
        p2_health = 3'd5;
        step(4);
        chk("m1_match_end", game_state, 4);
        chk("m1_match_winner", match_winner, 1);
        chk("m1_me_secs", secs_left, 0);
        step(3);
        chk("m1_me_hold", game_state, 4);
        chk("m1_me_hold_wins", p1_wins, 2);

        // match 2: timeout rounds, then a double KO on the expiry frame
        p1_health = 3'd5; p2_health = 3'd3;
        restart();
        chk("m2_cd_state", game_state, 1);
        chk("m2_wins_clear", {p1_wins, p2_wins}, 0);
        chk("m2_mw_clear", match_winner, 0);
        chk("m2_round", round_num, 1);
        step(8);
        chk("m2_fight", game_state, 2);
        step(11);
        chk("m2_fight_last", game_state, 2);
        chk("m2_fight_last_secs", secs_left, 1);
        step(1);
        chk("m2_r1_timeout", game_state, 3);
        chk("m2_r1_winner", round_winner, 1);
        chk("m2_r1_p1wins", p1_wins, 1);
        p1_health = 3'd4; p2_health = 3'd4;
        step(4);
        chk("m2_r2_cd", game_state, 1);
        step(20);
        chk("m2_r2_end", game_state, 3);
        chk("m2_r2_draw", round_winner, 3);
        chk("m2_r2_tally", {p1_wins, p2_wins}, 6'b001_000);
        step(4);
        chk("m2_r3_round", round_num, 3);
        step(19);
        chk("m2_r3_fight_last", game_state, 2);
        p1_health = 3'd0; p2_health = 3'd0;
        step(1);
        chk("m2_r3_dko", round_winner, 3);
        chk("m2_r3_state", game_state, 3);
        p1_health = 3'd4; p2_health = 3'd4;
        step(4);
        chk("m2_cap_end", game_state, 4);
        chk("m2_cap_winner", match_winner, 1);

        // match 3: three draws hit the round cap
        restart();
        for (int r = 1; r <= 3; r++) begin
            chk("m3_round", round_num, r);
            step(20);
            chk("m3_draw", round_winner, 3);
            step(4);
        end
        chk("m3_end", game_state, 4);
        chk("m3_mw_draw", match_winner, 3);
        chk("m3_tally", {p1_wins, p2_wins}, 0);

        // match 4: P2 wins a round, then reset mid-fight
        restart();
        step(8);
        p1_health = 3'd0;
        step(1);
        chk("m4_p2_winner", round_winner, 2);
        chk("m4_p2_wins", p2_wins, 1);
        p1_health = 3'd4;
        step(12);
        chk("m4_r2_fight", game_state, 2);
        step(3);
        rst = 1'b1;
        step(1);
        chk("mid_rst_state", game_state, 0);
        chk("mid_rst_outs", {secs_left, round_num, p1_wins, p2_wins, round_winner, match_winner}, 0);
        chk("mid_rst_pulse", round_reset, 0);
        rst = 1'b0;
        step(2);
        chk("post_rst_idle", game_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
